// File: rtl/rate_sequencer.sv
// rate_sequencer: steps the rate divider through up to four programmed {sel, count} phases.
// Define RATE_SEQUENCER_LOOP_EN to restart at phase 0 after DONE instead of returning to idle.
module rate_sequencer #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [1:0]       cfg_sel_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    input  logic             tick_i,
    output logic [1:0]       sel_o,
    output logic             div_resetn_o,
    output logic [1:0]       phase_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       value_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0]       LastPhase = 2'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       value_q, value_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             load_cnt_q, load_cnt_d;

    logic [1:0]       cfg_sel_q   [NUM_PHASES];
    logic [CNT_W-1:0] cfg_count_q [NUM_PHASES];

    logic [1:0]       cur_sel;
    logic [CNT_W-1:0] cur_count;
    logic             cfg_wr;

    assign cur_sel   = cfg_sel_q[phase_q];
    assign cur_count = cfg_count_q[phase_q];

    // Slots are only writable while idle so a running sequence never sees its table change.
    assign cfg_wr = cfg_we_i && (state_q == StIdle) && ({30'd0, cfg_addr_i} < NUM_PHASES);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < int'(NUM_PHASES); i++) begin
                cfg_sel_q[i]   <= 2'b00;
                cfg_count_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            cfg_sel_q[cfg_addr_i]   <= cfg_sel_i;
            cfg_count_q[cfg_addr_i] <= cfg_count_i;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= StIdle;
            phase_q     <= 2'b00;
            value_q     <= 4'd0;
            remaining_q <= '0;
            load_cnt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            value_q     <= value_d;
            remaining_q <= remaining_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        value_d     = value_q;
        remaining_d = remaining_q;
        load_cnt_d  = load_cnt_q;

        if (stop_i) begin
            // Abort keeps phase and value on the display.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d    = StLoad;
                        phase_d    = 2'b00;
                        value_d    = 4'd0;
                        load_cnt_d = 1'b0;
                    end
                end
                StLoad: begin
                    // Two cycles: divider latches the new rate, then reloads under reset.
                    if (!load_cnt_q) begin
                        if (cur_count == '0) begin
                            state_d = StDone;
                        end else begin
                            load_cnt_d = 1'b1;
                        end
                    end else begin
                        state_d     = StRun;
                        remaining_d = cur_count;
                    end
                end
                StRun: begin
                    if (tick_i) begin
                        value_d     = value_q + 4'd1;
                        remaining_d = remaining_q - CntOne;
                        if (remaining_q == CntOne) begin
                            if (phase_q == LastPhase) begin
                                state_d = StDone;
                            end else begin
                                state_d    = StLoad;
                                phase_d    = phase_q + 2'd1;
                                load_cnt_d = 1'b0;
                            end
                        end
                    end
                end
                StDone: begin
`ifdef RATE_SEQUENCER_LOOP_EN
                    // An empty slot 0 can never produce a tick, so it ends the run.
                    if (cfg_count_q[0] != '0) begin
                        state_d    = StLoad;
                        phase_d    = 2'b00;
                        load_cnt_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sel_o        = (state_q == StIdle) ? 2'b00 : cur_sel;
        div_resetn_o = (state_q == StRun);
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        phase_o      = phase_q;
        value_o      = value_q;
    end

endmodule

// File: doc/rate_sequencer.md
# rate_sequencer

Controller that sequences the rate-divider counter through a programmed list of up to four phases, each with its own rate select and number of enable pulses. It drives the divider's `Sel` and a per-phase divider reset, consumes the divider's one-cycle `Enable` pulse as `Tick`, and keeps a 4-bit tick count for the HEX display. It sits between the board switches/keys and the divider on the 5 kHz clock domain.

## Interface
- `NUM_PHASES`, default 4: number of phase slots; the `Cfg_addr` width is fixed at 2, so the legal range is 1..4.
- `CNT_W`, default 4: width of the per-phase pulse count.
- `Clock` in, 1 bit: 5 kHz system clock. All logic is on the rising edge.
- `Resetn` in, 1 bit: one clock; reset is asynchronous and active-low.
- `Start` in, 1 bit: begin the sequence at phase 0. Sampled per cycle.
- `Stop` in, 1 bit: abort to IDLE.
- `Cfg_we` in, 1 bit: write the phase slot at `Cfg_addr`.
- `Cfg_addr` in, 2 bits: phase slot index.
- `Cfg_sel` in, 2 bits: rate select for the slot (00 full, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz).
- `Cfg_count` in, CNT_W bits: enable pulses for the slot. 0 marks the end of the sequence.
- `Tick` in, 1 bit: `Enable` pulse from the divider.
- `Sel` out, 2 bits: rate select to the divider.
- `Div_resetn` out, 1 bit: active-low synchronous reset to the divider.
- `Phase` out, 2 bits: current phase index.
- `Busy` out, 1 bit: high in LOAD, RUN and DONE.
- `Done` out, 1 bit: one-cycle pulse at the end of the sequence.
- `Value` out, 4 bits: count of accepted ticks. Wraps modulo 16.

## Operation

**Configuration storage**
- Configuration array: `NUM_PHASES` × {sel[1:0], count[CNT_W-1:0]}.
- Write on `Cfg_we` only when `Busy`=0; writes while busy are dropped.
- Reset clears all slots to sel=00, count=0.

**States**
- IDLE
  - `Div_resetn`=0, `Sel`=00, `Busy`=0.
  - `Start`=1 (and `Stop`=0): go to LOAD with phase=0, `Value`=0.
- LOAD
  - Lasts exactly 2 cycles (a 1-bit sub-counter).
  - `Sel`=cfg[phase].sel, `Div_resetn`=0. This covers the divider's one-cycle registered rate plus its reload.
  - If cfg[phase].count==0 on the first LOAD cycle: go to DONE.
  - Otherwise, after the second cycle: go to RUN with remaining=cfg[phase].count.
  - `Tick` is ignored in LOAD.
- RUN
  - `Div_resetn`=1, `Sel` held.
  - Each `Tick`: `Value`+=1, remaining-=1.
  - On the `Tick` where remaining==1:
    - If phase==`NUM_PHASES`-1: go to DONE.
    - Else: phase+=1, go to LOAD.
- DONE
  - One cycle. `Done`=1, `Busy`=1, `Div_resetn`=0.
  - Next state is IDLE (see Configuration for the loop variant).

**Priorities and boundary conditions**
- `Stop` in any state: go to IDLE on the next edge. No `Done` pulse. `Value` and `Phase` are held for display.
- `Stop` and `Start` in the same cycle: `Stop` wins.
- `Start` while `Busy`: ignored.
- remaining is never 0 in RUN, so no underflow case exists.
- `Value` wraps 15→0 without a flag.

**Reset**
- `Resetn` low asynchronously forces: IDLE, phase=0, `Value`=0, `Sel`=00, `Div_resetn`=0, `Busy`=0, `Done`=0, config cleared.
- Reset mid-RUN discards the sequence. There is no resume.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- `Start` sampled at edge t:
  - `Busy`=1 from t+1.
  - LOAD occupies t+1 and t+2.
  - `Div_resetn`=1 from t+3.
  - The first divider `Enable` appears at t+3+rate-1 at the earliest.
- A `Tick` at edge t updates `Value` at t+1.
- Phase change:
  - The last `Tick` of phase k at edge t puts LOAD(k+1) at t+1 and t+2, with the new `Sel` visible from t+1.
- Sequence end:
  - The last `Tick` of the final phase at edge t gives `Done`=1 during t+1 only.
  - `Busy` falls at t+2.
- Zero-count slot at phase k: LOAD lasts 1 cycle, then DONE.
- Config write at edge t is readable by a `Start` at edge t+1.

## Configuration
- Macro: `RATE_SEQUENCER_LOOP_EN`.
- Defined:
  - After the final phase, or on a zero-count slot with phase>0, DONE pulses `Done` for one cycle, then goes to LOAD with phase=0 instead of IDLE.
  - `Value` is not cleared.
  - The sequence runs until `Stop` or `Resetn`.
  - A zero count in slot 0 still ends in IDLE.
- Undefined: DONE always goes to IDLE. This is single-shot.

## Test plan
- **Reset values:** reset asserted mid-RUN → all outputs at reset values within the same cycle (asynchronous); `Cfg` slots read back as 0 through a subsequent run that ends in DONE immediately.
- **Four-phase run:** slots {01,3},{00,2},{11,1},{10,4}, `Start`, `Tick` forced every 5th cycle → `Sel` sequence 01,00,11,10; `Value`=10 at end; exactly one `Done` pulse; each LOAD is 2 cycles with `Div_resetn`=0.
- **Zero-count slot:** slots {10,2},{01,0} → `Done` after 2 ticks plus 1 LOAD cycle; `Phase`=1 at `Done`.
- **Stop/Start priority:** `Stop` and `Start` in the same cycle while IDLE → stays IDLE; `Stop` during RUN after 2 ticks → IDLE next cycle, `Done`=0, `Value`=2 held.
- **Ignored inputs while busy:** `Cfg_we` and `Start` asserted during RUN → config unchanged and run not restarted; `Tick` during LOAD → `Value` unchanged.
- **Loop variant:** with `RATE_SEQUENCER_LOOP_EN`, slots {00,15},{00,15},{00,15},{00,15} → `Value` wraps 15→0, `Done` pulses every 60 ticks plus LOAD overhead, and the run continues until `Stop`.
